// File: rtl/cordic_ctrl_if.sv
// Handshake and control bundle between the CORDIC sequencer and its
// operand source / result consumer / cordic_core.
interface cordic_ctrl_if #(
  parameter int unsigned N = 7
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [8:1]    c;
  logic [CW-1:0] cnt;
  logic          busy;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  c,
    input  cnt,
    input  busy
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output c,
    output cnt,
    output busy
  );
endinterface

// File: rtl/cordic_ctrl.sv
// cordic_ctrl: sequencer for the iterative CORDIC datapath.
// Accepts one operand per valid/ready handshake, runs N-1 ITER cycles, writes
// X then Y through the shared scaler, then holds the result until taken.
// Optional feature macro: CORDIC_CTRL_PERF_EN adds a 16-bit completed-op counter.
module cordic_ctrl #(
  parameter int unsigned B = 14,
  parameter int unsigned N = 7
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CORDIC_CTRL_PERF_EN
  output logic [15:0] op_count,
`endif
  cordic_ctrl_if.slave bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_PEN  = CW'(N - 2);

  // Elaboration-time guard on the legal parameter space
  if (N < 2) begin : g_n_check
    $error("cordic_ctrl: N must be >= 2");
  end
  if (B == 0) begin : g_b_check
    $error("cordic_ctrl: B must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ITER = 3'd1,
    S_WRX  = 3'd2,
    S_WRY  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [8:1]    c_c;

  // Sequencer: state, iteration index and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            state      <= S_ITER;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_ITER: begin
          // Final increment lands on N-1, the index of the scaled last rotation
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_PEN) begin
            state <= S_WRX;
          end
        end
        S_WRX: begin
          state <= S_WRY;
        end
        S_WRY: begin
          state       <= S_DONE;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Core control word decode; IDLE loads coordinate/angle regs on the handshake edge
  always_comb begin
    c_c = '0;
    case (state)
      S_IDLE: begin
        c_c[1] = bus.in_valid;
        c_c[2] = bus.in_valid;
        c_c[8] = bus.in_valid;
      end
      S_ITER: begin
        c_c[2] = 1'b1;
      end
      S_WRX: begin
        c_c[6] = 1'b1;
      end
      S_WRY: begin
        c_c[5] = 1'b1;
        c_c[7] = 1'b1;
      end
      default: begin
        c_c = '0;
      end
    endcase
  end

  assign bus.c         = c_c;
  assign bus.cnt       = cnt_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

`ifdef CORDIC_CTRL_PERF_EN
  logic [15:0] op_count_q;

  // Completed-operation counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'h0000;
    end else if (out_valid_q && bus.out_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl (N=7): timeline model of one operation plus directed scenarios.
module tb_cordic_ctrl;

  localparam int unsigned N  = 7;
  localparam int unsigned B  = 14;
  localparam int          NI = 7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cordic_ctrl_if #(.N(N)) bus ();

`ifdef CORDIC_CTRL_PERF_EN
  logic [15:0] op_count;
`endif

  cordic_ctrl #(.B(B), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef CORDIC_CTRL_PERF_EN
    .op_count (op_count),
`endif
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Model: k = cycles since accept (-1 when idle). Offset 1..N-1 iterate,
  // N writes X, N+1 writes Y, N+2 onwards holds the result.
  int         k = -1;
  bit         model_on = 1'b0;
  logic [7:0] e_c;
  int         e_cnt;
  bit         e_ir, e_ov, e_busy;

  always @(negedge clk) begin
    if (model_on) begin
      if (k < 0) begin
        e_c = bus.in_valid ? 8'h83 : 8'h00;
        e_cnt = 0; e_ir = 1'b1; e_ov = 1'b0; e_busy = 1'b0;
      end else if (k <= NI - 1) begin
        e_c = 8'h02; e_cnt = k - 1; e_ir = 1'b0; e_ov = 1'b0; e_busy = 1'b1;
      end else if (k == NI) begin
        e_c = 8'h20; e_cnt = NI - 1; e_ir = 1'b0; e_ov = 1'b0; e_busy = 1'b1;
      end else if (k == NI + 1) begin
        e_c = 8'h50; e_cnt = NI - 1; e_ir = 1'b0; e_ov = 1'b0; e_busy = 1'b1;
      end else begin
        e_c = 8'h00; e_cnt = NI - 1; e_ir = 1'b0; e_ov = 1'b1; e_busy = 1'b1;
      end
      chk("model_c",         32'(bus.c),         32'(e_c));
      chk("model_cnt",       32'(bus.cnt),       32'(e_cnt));
      chk("model_in_ready",  32'(bus.in_ready),  32'(e_ir));
      chk("model_out_valid", 32'(bus.out_valid), 32'(e_ov));
      chk("model_busy",      32'(bus.busy),      32'(e_busy));
      if (rst) k = -1;
      else if (k < 0) begin
        if (bus.in_valid) k = 1;
      end else if (k < NI + 2) k = k + 1;
      else if (bus.out_ready) k = -1;
    end
  end

  // Leaves caller at the negedge where out_valid was first seen
  task automatic wait_out_valid(output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        at = cyc;
        break;
      end
      next_cycle();
    end
    if (!found) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mid();
      if (bus.busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!idle) chk("drain_timeout", 32'd0, 32'd1);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  int a, b, d, d2;
  int acc_q[$];
  bit ov_seen;

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) next_cycle();

    // Reset state
    mid();
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cnt",       32'(bus.cnt),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_c",         32'(bus.c),         32'd0);
    next_cycle();
    rst = 1'b0;
    model_on = 1'b1;

    // Single operation
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    mid();
    chk("t1_c_load", 32'(bus.c), 32'h83);
    next_cycle();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      mid();
      chk("t1_iter_cnt", 32'(bus.cnt), 32'(i - 1));
      chk("t1_iter_c",   32'(bus.c),   32'h02);
      next_cycle();
    end
    mid();
    chk("t1_wrx_c",   32'(bus.c),   32'h20);
    chk("t1_wrx_cnt", 32'(bus.cnt), 32'd6);
    next_cycle();
    mid();
    chk("t1_wry_c",   32'(bus.c),   32'h50);
    chk("t1_wry_cnt", 32'(bus.cnt), 32'd6);
    next_cycle();
    mid();
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    next_cycle();
    mid();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // Backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    mid();
    a = cyc;
    next_cycle();
    bus.in_valid = 1'b0;
    wait_out_valid(d);
    chk("t2_latency", 32'(d - a), 32'd9);
    for (int j = 0; j < 5; j++) begin
      chk("t2_hold_ov",   32'(bus.out_valid), 32'd1);
      chk("t2_hold_c",    32'(bus.c),         32'd0);
      chk("t2_hold_busy", 32'(bus.busy),      32'd1);
      next_cycle();
      if (j == 4) bus.out_ready = 1'b1;
      mid();
    end
    chk("t2_ov_sixth", 32'(bus.out_valid), 32'd1);
    next_cycle();
    mid();
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // in_valid held through the operation is ignored
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    mid();
    a = cyc;
    chk("t3_accept_ready", 32'(bus.in_ready), 32'd1);
    next_cycle();
    wait_out_valid(d);
    chk("t3_done_c",        32'(bus.c),        32'd0);
    chk("t3_done_in_ready", 32'(bus.in_ready), 32'd0);
    next_cycle(); mid();
    next_cycle(); mid();
    next_cycle();
    bus.out_ready = 1'b1;
    mid();
    next_cycle();
    mid();
    b = cyc;
    chk("t3_reaccept_ready", 32'(bus.in_ready), 32'd1);
    chk("t3_spacing",        32'(b - a),        32'd13);
    next_cycle();
    bus.in_valid = 1'b0;
    wait_out_valid(d2);
    chk("t3_second_latency", 32'(d2 - b), 32'd9);
    next_cycle();
    drain();

    // Reset mid-iteration
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    mid();
    next_cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      next_cycle();
    end
    rst = 1'b1;
    mid();
    chk("t4_cnt_at_rst", 32'(bus.cnt), 32'd3);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("t4_busy", 32'(bus.busy),      32'd0);
    chk("t4_cnt",  32'(bus.cnt),       32'd0);
    chk("t4_ov",   32'(bus.out_valid), 32'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      mid();
      if (bus.out_valid === 1'b1) ov_seen = 1'b1;
    end
    chk("t4_no_result", 32'(ov_seen), 32'd0);
    next_cycle();

    // Back-to-back
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mid();
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      next_cycle();
    end
    chk("t5_accepts", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() >= 3) begin
      chk("t5_gap1", 32'(acc_q[1] - acc_q[0]), 32'd10);
      chk("t5_gap2", 32'(acc_q[2] - acc_q[1]), 32'd10);
    end
    drain();

`ifdef CORDIC_CTRL_PERF_EN
    // Counter wrap
    force dut.op_count_q = 16'hFFFE;
    mid();
    release dut.op_count_q;
    next_cycle();
    chk("t6_forced", 32'(op_count), 32'h0000FFFE);
    for (int n = 0; n < 2; n++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      mid();
      next_cycle();
      bus.in_valid = 1'b0;
      wait_out_valid(d);
      next_cycle();
      mid();
      chk("t6_count", 32'(op_count), (n == 0) ? 32'h0000FFFF : 32'h00000000);
      next_cycle();
    end
`endif

    model_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
